// File: rtl/cmp_checker_p_if.sv
// cmp_checker_p_if: operand and DUT-flag bundle observed by the comparator checker
// Signals: in_valid/in_a/in_b are the operands offered to the comparator DUT,
//          dut_eq/dut_neq/dut_grt/dut_lss are the flags the DUT returns.
// Modports: master drives the bundle (bench/wrapper), slave observes it (checker).
interface cmp_checker_p_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             dut_eq;
    logic             dut_neq;
    logic             dut_grt;
    logic             dut_lss;
    modport master (output in_valid, in_a, in_b, dut_eq, dut_neq, dut_grt, dut_lss);
    modport slave  (input  in_valid, in_a, in_b, dut_eq, dut_neq, dut_grt, dut_lss);
endinterface

// File: rtl/cmp_checker_p.sv
// cmp_checker_p: pipelined self-checking monitor for an eq/neq/grt/lss comparator
// Ports: clk, resetn (async active-low), enable (accept transactions), clr (sync clear),
//        bus (operands + DUT flags), chk_valid/chk_fail/mism (per-check result),
//        pass_cnt/fail_cnt (saturating), err_sticky, rst_err (flags nonzero right after reset),
//        ff_a/ff_b/ff_mism (first failing check), state (0 IDLE, 1 RUN, 2 FAILED).
module cmp_checker_p #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    parameter int SIGNED  = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clr,
    cmp_checker_p_if.slave   bus,
    output logic             chk_valid,
    output logic             chk_fail,
    output logic [3:0]       mism,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic             rst_err,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic [3:0]       ff_mism,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAILED = 2'd2} state_t;
    // Stages 0..LATENCY-1 model the DUT latency; stage LATENCY holds the entry
    // together with the flags sampled at the same edge, so the compare is registered.
    localparam int S = LATENCY;
    logic [S:0]       vld_q, vld_d;
    logic [WIDTH-1:0] a_q [S+1];
    logic [WIDTH-1:0] a_d [S+1];
    logic [WIDTH-1:0] b_q [S+1];
    logic [WIDTH-1:0] b_d [S+1];
    logic [3:0]       flg_q, flg_d;
    logic             post_q;
    logic             chk_valid_q, chk_valid_d, chk_fail_q, chk_fail_d;
    logic [3:0]       mism_q, mism_d, ff_mism_q, ff_mism_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic             err_q, err_d, rst_err_q, rst_err_d;
    logic [WIDTH-1:0] ff_a_q, ff_a_d, ff_b_q, ff_b_d;
    state_t           state_q, state_d;
    logic             a_eq, a_gt, a_lt, chk, fail, cap, post_err;
    logic [3:0]       mism_n;
    always_comb begin
        a_eq      = a_q[S] == b_q[S];
        a_gt      = (SIGNED != 0) ? ($signed(a_q[S]) > $signed(b_q[S])) : (a_q[S] > b_q[S]);
        a_lt      = !a_eq && !a_gt;
        mism_n    = {a_lt, a_gt, !a_eq, a_eq} ^ flg_q;
        chk       = vld_q[S] && !clr;
        fail      = chk && (mism_n != 4'd0);
        cap       = fail && (state_q != FAILED);
        post_err  = !post_q && (bus.dut_eq || bus.dut_neq || bus.dut_grt || bus.dut_lss);
        vld_d[0]  = !clr && bus.in_valid && enable;
        a_d[0]    = bus.in_a;
        b_d[0]    = bus.in_b;
        for (int i = 1; i <= S; i++) begin
            vld_d[i] = !clr && vld_q[i-1];
            a_d[i]   = a_q[i-1];
            b_d[i]   = b_q[i-1];
        end
        flg_d       = {bus.dut_lss, bus.dut_grt, bus.dut_neq, bus.dut_eq};
        chk_valid_d = chk;
        chk_fail_d  = fail;
        mism_d      = clr ? 4'd0 : chk ? mism_n : mism_q;
        pass_d      = clr ? '0 : (chk && !fail && pass_q != '1) ? pass_q + CNT_W'(1) : pass_q;
        fail_d      = clr ? '0 : (fail && fail_q != '1) ? fail_q + CNT_W'(1) : fail_q;
        err_d       = !clr && (err_q || fail || post_err);
        rst_err_d   = !clr && (rst_err_q || post_err);
        ff_a_d      = clr ? '0 : cap ? a_q[S] : ff_a_q;
        ff_b_d      = clr ? '0 : cap ? b_q[S] : ff_b_q;
        ff_mism_d   = clr ? 4'd0 : cap ? mism_n : ff_mism_q;
        state_d     = clr ? (enable ? RUN : IDLE) :
                      fail ? FAILED :
                      (state_q == IDLE && enable) ? RUN :
                      (state_q == RUN && !enable) ? IDLE : state_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q       <= '0;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            flg_q       <= '0;
            post_q      <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_fail_q  <= 1'b0;
            mism_q      <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            err_q       <= 1'b0;
            rst_err_q   <= 1'b0;
            ff_a_q      <= '0;
            ff_b_q      <= '0;
            ff_mism_q   <= '0;
            state_q     <= IDLE;
        end else begin
            vld_q       <= vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            flg_q       <= flg_d;
            post_q      <= 1'b1;
            chk_valid_q <= chk_valid_d;
            chk_fail_q  <= chk_fail_d;
            mism_q      <= mism_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            err_q       <= err_d;
            rst_err_q   <= rst_err_d;
            ff_a_q      <= ff_a_d;
            ff_b_q      <= ff_b_d;
            ff_mism_q   <= ff_mism_d;
            state_q     <= state_d;
        end
    end
    assign chk_valid  = chk_valid_q;
    assign chk_fail   = chk_fail_q;
    assign mism       = mism_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign err_sticky = err_q;
    assign rst_err    = rst_err_q;
    assign ff_a       = ff_a_q;
    assign ff_b       = ff_b_q;
    assign ff_mism    = ff_mism_q;
    assign state      = state_q;
endmodule

// File: tb/tb_cmp_checker_p.sv
// tb_cmp_checker_p: scoreboard bench for cmp_checker_p across four parameter sets
module tb_cmp_checker_p;
    logic        clk = 1'b0;
    logic        resetn, enable, clr, in_valid, force_eq;
    logic [31:0] in_a, in_b, ra, rb;
    logic [3:0]  inj;
    int          n_vec = 0, n_bad = 0, d_checks = 0;
    logic [4:0]  qa[$], qb[$];
    logic [4:0]  ea, eb;
    logic [3:0]  p1, p3[3], p4[4];
    logic        cv[4], cf[4], es[4], re[4];
    logic [3:0]  mm[4], fm[4];
    logic [15:0] pc[4], fc[4];
    logic [3:0]  pc4, fc4;
    logic [31:0] fa[4], fb[4];
    logic [1:0]  st[4];
    always #5 clk = ~clk;
    function automatic logic [3:0] flags(input logic [31:0] a, b, input bit s);
        logic gt, lt;
        gt = s ? ($signed(a) > $signed(b)) : (a > b);
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        return {lt, gt, a != b, a == b};
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Behavioural comparator DUTs (unsigned, latency 1/3/4) with optional flag corruption.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p1 <= '0;
            p3 <= '{default: '0};
            p4 <= '{default: '0};
        end else begin
            p1    <= flags(in_a, in_b, 0) ^ inj;
            p3[0] <= flags(in_a, in_b, 0) ^ inj;
            p3[1] <= p3[0];
            p3[2] <= p3[1];
            p4[0] <= flags(in_a, in_b, 0) ^ inj;
            p4[1] <= p4[0];
            p4[2] <= p4[1];
            p4[3] <= p4[2];
        end
    end
    cmp_checker_p_if #(.WIDTH(32)) if1 ();
    cmp_checker_p_if #(.WIDTH(32)) if3 ();
    cmp_checker_p_if #(.WIDTH(32)) if4 ();
    assign if1.in_valid = in_valid; assign if1.in_a = in_a; assign if1.in_b = in_b;
    assign if3.in_valid = in_valid; assign if3.in_a = in_a; assign if3.in_b = in_b;
    assign if4.in_valid = in_valid; assign if4.in_a = in_a; assign if4.in_b = in_b;
    assign {if1.dut_lss, if1.dut_grt, if1.dut_neq, if1.dut_eq} = p1 | {3'b000, force_eq};
    assign {if3.dut_lss, if3.dut_grt, if3.dut_neq, if3.dut_eq} = p3[2];
    assign {if4.dut_lss, if4.dut_grt, if4.dut_neq, if4.dut_eq} = p4[3];
    cmp_checker_p #(.WIDTH(32), .LATENCY(3), .SIGNED(0), .CNT_W(16)) u_a (
        .clk(clk), .resetn(resetn), .enable(enable), .clr(clr), .bus(if3),
        .chk_valid(cv[0]), .chk_fail(cf[0]), .mism(mm[0]), .pass_cnt(pc[0]), .fail_cnt(fc[0]),
        .err_sticky(es[0]), .rst_err(re[0]), .ff_a(fa[0]), .ff_b(fb[0]), .ff_mism(fm[0]), .state(st[0]));
    cmp_checker_p #(.WIDTH(32), .LATENCY(3), .SIGNED(1), .CNT_W(16)) u_b (
        .clk(clk), .resetn(resetn), .enable(enable), .clr(clr), .bus(if3),
        .chk_valid(cv[1]), .chk_fail(cf[1]), .mism(mm[1]), .pass_cnt(pc[1]), .fail_cnt(fc[1]),
        .err_sticky(es[1]), .rst_err(re[1]), .ff_a(fa[1]), .ff_b(fb[1]), .ff_mism(fm[1]), .state(st[1]));
    cmp_checker_p #(.WIDTH(32), .LATENCY(1), .SIGNED(0), .CNT_W(4)) u_c (
        .clk(clk), .resetn(resetn), .enable(enable), .clr(clr), .bus(if1),
        .chk_valid(cv[2]), .chk_fail(cf[2]), .mism(mm[2]), .pass_cnt(pc4), .fail_cnt(fc4),
        .err_sticky(es[2]), .rst_err(re[2]), .ff_a(fa[2]), .ff_b(fb[2]), .ff_mism(fm[2]), .state(st[2]));
    cmp_checker_p #(.WIDTH(32), .LATENCY(4), .SIGNED(0), .CNT_W(16)) u_d (
        .clk(clk), .resetn(resetn), .enable(enable), .clr(clr), .bus(if4),
        .chk_valid(cv[3]), .chk_fail(cf[3]), .mism(mm[3]), .pass_cnt(pc[3]), .fail_cnt(fc[3]),
        .err_sticky(es[3]), .rst_err(re[3]), .ff_a(fa[3]), .ff_b(fb[3]), .ff_mism(fm[3]), .state(st[3]));
    // Scoreboard: each accepted transaction pushes the expected {fail, mism} per checker.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
        logic [3:0] mb;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        inj      = m;
        mb       = flags(a, b, 1) ^ flags(a, b, 0) ^ m;
        if (enable) begin
            qa.push_back({|m, m});
            qb.push_back({|mb, mb});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        inj      = '0;
    endtask
    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask
    always @(negedge clk) begin
        if (cv[0]) begin
            if (qa.size() == 0) check("A_spurious_chk", cv[0], 0);
            else begin
                ea = qa.pop_front();
                check("A_chk_fail", cf[0], ea[4]);
                check("A_mism", mm[0], ea[3:0]);
            end
        end
        if (cv[1]) begin
            if (qb.size() == 0) check("B_spurious_chk", cv[1], 0);
            else begin
                eb = qb.pop_front();
                check("B_chk_fail", cf[1], eb[4]);
                check("B_mism", mm[1], eb[3:0]);
            end
        end
        if (cv[3]) d_checks++;
    end
    initial begin
        resetn = 1'b0; enable = 1'b0; clr = 1'b0; in_valid = 1'b0; force_eq = 1'b0;
        in_a = '0; in_b = '0; inj = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_state_A", {cv[0], cf[0], mm[0], pc[0], fc[0], es[0], re[0], st[0]}, 0);
        check("rst_ffa_D", fa[3], 0);
        resetn   = 1'b1;
        force_eq = 1'b1;
        @(posedge clk); #1;
        force_eq = 1'b0;
        check("rst_err_A", re[0], 0);
        check("rst_err_C", re[2], 1);
        check("rst_sticky_C", es[2], 1);
        check("rst_failcnt_C", fc4, 0);
        check("rst_state_C", st[2], 0);
        enable = 1'b1;
        send(32'hFFFF_FFFF, 32'h1, 4'd0);
        repeat (8) @(posedge clk); #1;
        check("sgn_mism_B", mm[1], 4'b1100);
        check("sgn_ffa_B", fa[1], 32'hFFFF_FFFF);
        check("sgn_ffmism_B", fm[1], 4'b1100);
        check("sgn_state_B", st[1], 2);
        check("sgn_pass_A", pc[0], 1);
        check("sgn_state_A", st[0], 1);
        pulse_clr();
        check("clr_cnt_B", {pc[1], fc[1], es[1], fm[1]}, 0);
        check("clr_ffa_B", fa[1], 0);
        check("clr_state_B", st[1], 1);
        check("clr_rsterr_C", re[2], 0);
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = (i % 7 == 0) ? ra : $urandom;
            if (i == 1) begin ra = 32'h0; rb = 32'hFFFF_FFFF; end
            if (i == 2) begin ra = 32'hFFFF_FFFF; rb = 32'h0; end
            send(ra, rb, 4'd0);
        end
        repeat (8) @(posedge clk); #1;
        check("rnd_pass_A", pc[0], 1000);
        check("rnd_fail_A", fc[0], 0);
        check("rnd_state_A", st[0], 1);
        check("sat_pass_C", pc4, 15);
        check("sat_fail_C", fc4, 0);
        pulse_clr();
        for (int i = 0; i < 20; i++)
            send(32'(i * 7 + 3), 32'd50, (i == 4) ? 4'b0001 : (i == 8) ? 4'b0110 : 4'b0000);
        repeat (8) @(posedge clk); #1;
        check("inj_fail_A", fc[0], 2);
        check("inj_pass_A", pc[0], 18);
        check("inj_ffa_A", fa[0], 31);
        check("inj_ffb_A", fb[0], 50);
        check("inj_ffmism_A", fm[0], 4'b0001);
        check("inj_state_A", st[0], 2);
        check("inj_sticky_A", es[0], 1);
        pulse_clr();
        check("clr2_cnt_A", {pc[0], fc[0], es[0], fm[0], mm[0], cv[0]}, 0);
        check("clr2_ffa_A", fa[0], 0);
        check("clr2_state_A", st[0], 1);
        d_checks = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) enable = 1'b0;
            send(32'(i + 100), 32'd103, 4'd0);
        end
        repeat (4) @(posedge clk); #1;
        check("drop_checks_D", d_checks, 4);
        check("drop_pass_D", pc[3], 4);
        check("drop_state_D", st[3], 0);
        enable = 1'b1;
        send(32'd1, 32'd2, 4'd0);
        send(32'd3, 32'd3, 4'd0);
        #2 resetn = 1'b0;
        #1;
        check("arst_out_D", {cv[3], cf[3], mm[3], pc[3], fc[3], es[3], re[3], fm[3], st[3]}, 0);
        check("arst_ffa_D", fa[3], 0);
        check("arst_out_A", {cv[0], pc[0], st[0]}, 0);
        qa.delete();
        qb.delete();
        d_checks = 0;
        @(posedge clk); #3;
        resetn = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("arst_nochk_D", d_checks, 0);
        check("arst_pass_D", pc[3], 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
